// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer
//   Collects byte strobes from the UART receiver into command frames of the form
//   SYNC, OP, LEN, LEN payload bytes, CSUM. CSUM is the XOR of OP, LEN and every
//   payload byte. A good frame is held on a valid/ready port and its payload can be
//   read at random through a registered read port. Bad frames produce one-cycle
//   error strobes and the framer returns to hunting for SYNC.
//
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_finish/rx_error    receiver strobes, rx_data valid with rx_finish
//   cmd_valid/cmd_ready   held-command handshake; cmd_op, cmd_len describe it
//   pl_addr -> pl_data    payload read, one cycle latency, 0 beyond cmd_len
//   busy                  framer is anywhere except SYNC
//   err_*                 one-cycle error strobes (csum, frame, len, timeout, overrun)
//
//   state    | meaning
//   S_SYNC   | idle, waiting for SYNC_BYTE
//   S_OP     | expecting opcode byte
//   S_LEN    | expecting length byte
//   S_PAYLOAD| collecting payload bytes into the buffer
//   S_CSUM   | expecting checksum byte
//   S_HOLD   | command presented, waiting for cmd_ready
module uart_cmd_framer #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned TIMEOUT   = 255,
  localparam int unsigned LW = $clog2(MAX_LEN + 1),
  localparam int unsigned AW = $clog2(MAX_LEN),
  localparam int unsigned TW = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_finish,
  input  logic          rx_error,
  input  logic [7:0]    rx_data,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [7:0]    cmd_op,
  output logic [LW-1:0] cmd_len,
  input  logic [AW-1:0] pl_addr,
  output logic [7:0]    pl_data,
  output logic          busy,
  output logic          err_csum,
  output logic          err_frame,
  output logic          err_len,
  output logic          err_timeout,
  output logic          err_overrun
);

  typedef enum logic [2:0] {
    S_SYNC, S_OP, S_LEN, S_PAYLOAD, S_CSUM, S_HOLD
  } state_t;

  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(TIMEOUT);

  state_t        state_q, state_d;
  logic [7:0]    op_q, xor_q;
  logic [LW-1:0] len_q, idx_q;
  logic [TW-1:0] gap_q;
  logic [7:0]    pl_mem [MAX_LEN];

  logic byte_ok, active, gap_tc, last_byte;
  logic ld_op, ld_len, wr_pl;
  logic csum_d, frame_d, len_d, timeout_d, overrun_d;

  // an rx_error in the same cycle discards the byte
  assign byte_ok   = rx_finish & ~rx_error;
  assign active    = (state_q == S_OP) || (state_q == S_LEN) ||
                     (state_q == S_PAYLOAD) || (state_q == S_CSUM);
  // down-counter reloaded on every byte; terminal count is the last idle cycle allowed
  assign gap_tc    = (gap_q == TW'(1));
  assign last_byte = (idx_q == len_q - LW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_SYNC;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ld_op     = 1'b0;
    ld_len    = 1'b0;
    wr_pl     = 1'b0;
    csum_d    = 1'b0;
    frame_d   = 1'b0;
    len_d     = 1'b0;
    timeout_d = 1'b0;
    overrun_d = 1'b0;
    case (state_q)
      S_SYNC: begin
        if (byte_ok && rx_data == SYNC_BYTE) state_d = S_OP;
      end
      S_OP, S_LEN, S_PAYLOAD, S_CSUM: begin
        if (rx_error) begin
          frame_d = 1'b1;
          state_d = S_SYNC;
        end else if (rx_finish) begin
          case (state_q)
            S_OP: begin
              ld_op   = 1'b1;
              state_d = S_LEN;
            end
            S_LEN: begin
              if (rx_data > MAX_LEN_B) begin
                len_d   = 1'b1;
                state_d = S_SYNC;
              end else begin
                ld_len  = 1'b1;
                state_d = (rx_data == 8'h00) ? S_CSUM : S_PAYLOAD;
              end
            end
            S_PAYLOAD: begin
              wr_pl = 1'b1;
              if (last_byte) state_d = S_CSUM;
            end
            default: begin
              if (rx_data == xor_q) begin
                state_d = S_HOLD;
              end else begin
                csum_d  = 1'b1;
                state_d = S_SYNC;
              end
            end
          endcase
        end else if (gap_tc) begin
          timeout_d = 1'b1;
          state_d   = S_SYNC;
        end
      end
      S_HOLD: begin
        if (byte_ok)   overrun_d = 1'b1;
        if (cmd_ready) state_d   = S_SYNC;
      end
      default: state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= 8'h00;
      xor_q       <= 8'h00;
      len_q       <= '0;
      idx_q       <= '0;
      gap_q       <= GAP_LOAD;
      pl_data     <= 8'h00;
      err_csum    <= 1'b0;
      err_frame   <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_csum    <= csum_d;
      err_frame   <= frame_d;
      err_len     <= len_d;
      err_timeout <= timeout_d;
      err_overrun <= overrun_d;
      if (ld_op) begin
        op_q  <= rx_data;
        xor_q <= rx_data;
      end
      if (ld_len) begin
        len_q <= rx_data[LW-1:0];
        xor_q <= xor_q ^ rx_data;
        idx_q <= '0;
      end
      if (wr_pl) begin
        idx_q <= idx_q + LW'(1);
        xor_q <= xor_q ^ rx_data;
      end
      if (rx_finish || !active) gap_q <= GAP_LOAD;
      else                      gap_q <= gap_q - TW'(1);
      pl_data <= (LW'(pl_addr) < len_q) ? pl_mem[pl_addr] : 8'h00;
    end
  end

  // payload buffer deliberately has no reset
  always_ff @(posedge clk) begin
    if (wr_pl) pl_mem[idx_q[AW-1:0]] <= rx_data;
  end

  assign cmd_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_SYNC);
  assign cmd_op    = op_q;
  assign cmd_len   = len_q;

endmodule
